// File: rtl/pll_drp_loader.sv
// pll_drp_loader: buffers host DRP patch entries and replays them into the PLL
// reconfiguration sequencer. PLL_DRP_LOADER_TIMEOUT_EN adds the wait-state timeout.
module pll_drp_loader #(
  parameter int g_trig_hold = 8,
  parameter int g_timeout   = 65535
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        ld_valid_i,
  input  logic [36:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        commit_i,
  output logic [31:0] r_pll_ctl0_o,
  output logic [31:0] r_pll_ctl1_o,
  input  logic        seq_busy_i,
  input  logic [31:0] pll_status_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [4:0]  n_entries_o
);
  localparam int DEPTH  = 31;
  localparam int HOLD_W = $clog2(g_trig_hold + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_ent_t;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD, S_TRIG,
    S_WAIT_BUSY, S_WAIT_IDLE, S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  state_t            state;
  drp_ent_t          ent_q [DEPTH];
  drp_ent_t          ent_0, ent_nx;
  logic [4:0]        cnt_q, seq_n_q, idx_q, idx_nx, addr_q, hi_q;
  logic              we_q, trig_q;
  logic [31:0]       ctl1_q;
  logic [HOLD_W-1:0] hold_q;
  logic [1:0]        busy_sync, lock_sync;
  logic              busy_s, lock_s, ld_acc, tmo_hit;
  logic              unused_status;

  assign ld_ready_o    = (state == S_IDLE) && (cnt_q != 5'd31);
  assign ld_acc        = ld_valid_i && ld_ready_o;
  assign busy_o        = (state != S_IDLE);
  assign n_entries_o   = cnt_q;
  assign r_pll_ctl0_o  = {8'd0, 3'd0, hi_q, 4'd0, seq_n_q, trig_q, we_q, addr_q};
  assign r_pll_ctl1_o  = ctl1_q;
  assign idx_nx        = idx_q + 5'd1;
  assign ent_0         = ent_q[5'd0];
  assign ent_nx        = ent_q[idx_nx];
  assign busy_s        = busy_sync[1];
  assign lock_s        = lock_sync[1];
  assign unused_status = ^{pll_status_i[31:19], pll_status_i[17:0]};

  // Entry storage is not reset: a zero count is what makes it empty.
  always_ff @(posedge clk_sys_i)
    if (ld_acc) ent_q[cnt_q] <= drp_ent_t'(ld_data_i);

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_sync <= '0;
      lock_sync <= '0;
    end else begin
      busy_sync <= {busy_sync[0], seq_busy_i};
      lock_sync <= {lock_sync[0], pll_status_i[18]};
    end
  end

`ifdef PLL_DRP_LOADER_TIMEOUT_EN
  localparam logic [15:0] TMO_LD = 16'(g_timeout);
  logic [15:0] tmr_q;
  logic        tmr_load;

  assign tmr_load = (state == S_TRIG && hold_q == '0) ||
                    (state == S_WAIT_BUSY && busy_s) ||
                    (state == S_WAIT_IDLE && !busy_s);
  // Hit one cycle early so err_o lands in the cycle the count reaches zero.
  assign tmo_hit  = (state inside {S_WAIT_BUSY, S_WAIT_IDLE, S_WAIT_LOCK}) && (tmr_q == 16'd1);

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i)          tmr_q <= '0;
    else if (tmr_load)     tmr_q <= TMO_LD;
    else if (tmr_q != '0)  tmr_q <= tmr_q - 16'd1;
  end
`else
  localparam int unused_tmo = g_timeout;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      seq_n_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      trig_q  <= 1'b0;
      ctl1_q  <= '0;
      hold_q  <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (ld_acc) cnt_q <= cnt_q + 5'd1;
      case (state)
        S_IDLE: if (commit_i) begin
          seq_n_q <= cnt_q;
          idx_q   <= '0;
          if (cnt_q == '0) err_o <= 1'b1;
          else begin
            state  <= S_WR_SETUP;
            addr_q <= '0;
            hi_q   <= ent_0.addr;
            ctl1_q <= {ent_0.mask, ent_0.data};
          end
        end
        S_WR_SETUP: begin
          we_q  <= 1'b1;
          state <= S_WR_STROBE;
        end
        S_WR_STROBE: begin
          we_q  <= 1'b0;
          state <= S_WR_HOLD;
        end
        S_WR_HOLD: if (idx_q == seq_n_q - 5'd1) begin
          state  <= S_TRIG;
          trig_q <= 1'b1;
          hold_q <= HOLD_W'(g_trig_hold - 1);
          addr_q <= '0;
          hi_q   <= '0;
          ctl1_q <= '0;
        end else begin
          state  <= S_WR_SETUP;
          idx_q  <= idx_nx;
          addr_q <= idx_nx;
          hi_q   <= ent_nx.addr;
          ctl1_q <= {ent_nx.mask, ent_nx.data};
        end
        S_TRIG: if (hold_q == '0) begin
          trig_q <= 1'b0;
          state  <= S_WAIT_BUSY;
        end else hold_q <= hold_q - 1'b1;
        S_WAIT_BUSY: if (busy_s) state <= S_WAIT_IDLE;
          else if (tmo_hit) begin state <= S_ERR; err_o <= 1'b1; end
        S_WAIT_IDLE: if (!busy_s) state <= S_WAIT_LOCK;
          else if (tmo_hit) begin state <= S_ERR; err_o <= 1'b1; end
        S_WAIT_LOCK: if (lock_s) begin state <= S_DONE; done_o <= 1'b1; end
          else if (tmo_hit) begin state <= S_ERR; err_o <= 1'b1; end
        S_DONE, S_ERR: begin
          cnt_q <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_drp_loader.sv
// tb_pll_drp_loader: randomized scoreboard bench; a monitor pops expected write
// strobes, trigger bursts and done/err outcomes pushed by the stimulus.
`timescale 1ns/1ps
module tb_pll_drp_loader;
  localparam int HOLD = 8;
  localparam int TMO  = 100;

  logic        clk_sys_i = 1'b0, rst_n_i = 1'b0;
  logic        ld_valid_i = 1'b0, commit_i = 1'b0, seq_busy_i = 1'b0;
  logic [36:0] ld_data_i = '0;
  logic [31:0] pll_status_i = '0;
  logic        ld_ready_o, busy_o, done_o, err_o;
  logic [31:0] r_pll_ctl0_o, r_pll_ctl1_o;
  logic [4:0]  n_entries_o;

  pll_drp_loader #(.g_trig_hold(HOLD), .g_timeout(TMO)) dut (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .commit_i(commit_i), .r_pll_ctl0_o(r_pll_ctl0_o), .r_pll_ctl1_o(r_pll_ctl1_o),
    .seq_busy_i(seq_busy_i), .pll_status_i(pll_status_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .n_entries_o(n_entries_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int tests = 0, fails = 0;
  logic [36:0] model  [$];   // entries the loader should hold
  logic [46:0] exp_wr [$];   // {count, index, entry}
  logic [4:0]  exp_trig [$];
  logic        exp_end [$];  // 1 = err_o, 0 = done_o

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Control words the sequencer should see while writing entry e.
  function automatic logic [63:0] exp_ctl(input logic [46:0] e, input logic we);
    int cnt  = int'(e[46:42]);
    int idx  = int'(e[41:37]);
    int addr = int'(e[36:32]);
    logic [31:0] c0 = 32'(addr * 65536 + cnt * 128 + (we ? 32 : 0) + idx);
    return {c0, e[31:0]};
  endfunction

  function automatic logic [36:0] rnd_ent();
    return {5'($urandom_range(0, 31)), 32'($urandom)};
  endfunction

  task automatic set_lock(input logic b);
    pll_status_i     = $urandom;
    pll_status_i[18] = b;
  endtask

  initial begin : monitor
    logic [46:0] e, hold_e;
    logic        hold_pend, trig_prev;
    int          tlen;
    logic [31:0] c0_prev, c1_prev;
    hold_pend = 1'b0; trig_prev = 1'b0; tlen = 0; hold_e = '0;
    c0_prev = '0; c1_prev = '0;
    forever begin
      @(negedge clk_sys_i);
      if (!rst_n_i) begin
        hold_pend = 1'b0; trig_prev = 1'b0; tlen = 0;
      end else begin
        if (r_pll_ctl0_o[5]) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            e = exp_wr.pop_front();
            chk("wr_strobe", {r_pll_ctl0_o, r_pll_ctl1_o}, exp_ctl(e, 1'b1));
            chk("wr_setup", {c0_prev, c1_prev}, exp_ctl(e, 1'b0));
            hold_e = e; hold_pend = 1'b1;
          end
        end else if (hold_pend) begin
          chk("wr_hold", {r_pll_ctl0_o, r_pll_ctl1_o}, exp_ctl(hold_e, 1'b0));
          hold_pend = 1'b0;
        end
        if (r_pll_ctl0_o[6]) begin
          if (!trig_prev) begin
            if (exp_trig.size() == 0) chk("trig_unexpected", 1, 0);
            else chk("trig_ctl0", r_pll_ctl0_o[11:6], {exp_trig.pop_front(), 1'b1});
          end
          tlen++;
        end else if (trig_prev) begin
          chk("trig_len", tlen, HOLD);
          tlen = 0;
        end
        trig_prev = r_pll_ctl0_o[6];
        if (done_o || err_o) begin
          if (exp_end.size() == 0) chk("end_unexpected", {done_o, err_o}, 0);
          else chk("end_kind", {done_o, err_o}, exp_end.pop_front() ? 2'b01 : 2'b10);
        end
      end
      c0_prev = r_pll_ctl0_o;
      c1_prev = r_pll_ctl1_o;
    end
  end

  task automatic load_one(input logic [36:0] d, input logic v);
    logic rdy = (model.size() < 31);
    ld_valid_i = v;
    ld_data_i  = d;
    chk("ld_ready", ld_ready_o, rdy);
    if (v && rdy) model.push_back(d);
    @(negedge clk_sys_i);
    ld_valid_i = 1'b0;
  endtask

  task automatic wait_trig(input logic v, output int c);
    c = 0;
    while (r_pll_ctl0_o[6] !== v && c < 400) begin @(negedge clk_sys_i); c++; end
    if (c >= 400) chk("trig_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy_o !== 1'b0 && c < 2000) begin @(negedge clk_sys_i); c++; end
    if (c >= 2000) chk("idle_wait_expired", 0, 1);
  endtask

  // mode 0: normal sequencer, 1: extra commit during WAIT_LOCK, 2: busy never comes
  task automatic commit_seq(input int mode);
    int n = model.size();
    int k = 0;
    int c;
    for (int i = 0; i < n; i++) exp_wr.push_back({5'(n), 5'(i), model[i]});
    if (n > 0) exp_trig.push_back(5'(n));
    exp_end.push_back(n == 0 || mode == 2);
    set_lock(1'b0);
    commit_i = 1'b1;
    @(negedge clk_sys_i);
    commit_i = 1'b0;
    if (n == 0) chk("empty_err", {err_o, r_pll_ctl0_o[6:5], busy_o}, 4'b1000);
    else begin
      wait_trig(1'b1, c);
      chk("trig_latency", c, 3 * n);
      wait_trig(1'b0, c);
      if (mode == 2) begin
        while (!err_o && k < 300) begin @(negedge clk_sys_i); k++; end
        chk("tmo_cycle", k, TMO);
      end else begin
        repeat ($urandom_range(0, 5)) @(negedge clk_sys_i);
        seq_busy_i = 1'b1;
        repeat ($urandom_range(3, 25)) @(negedge clk_sys_i);
        seq_busy_i = 1'b0;
        repeat (6) @(negedge clk_sys_i);
        if (mode == 1) begin
          commit_i = 1'b1;
          @(negedge clk_sys_i);
          commit_i = 1'b0;
        end
        set_lock(1'b1);
      end
    end
    wait_idle();
    chk("n_after", n_entries_o, 0);
    chk("ready_after", ld_ready_o, 1);
    set_lock(1'b0);
    model.delete();
  endtask

  initial begin : stim
    int seen;
    set_lock(1'b0);
    repeat (3) @(negedge clk_sys_i);
    chk("rst_ctl", {r_pll_ctl0_o, r_pll_ctl1_o}, 64'd0);
    chk("rst_flags", {ld_ready_o, busy_o, done_o, err_o, n_entries_o}, {1'b1, 3'b0, 5'd0});
    rst_n_i = 1'b1;
    @(negedge clk_sys_i);

    load_one({5'h08, 16'h1000, 16'h0041}, 1'b1);
    load_one({5'h0A, 16'h0000, 16'h1234}, 1'b1);
    chk("n_two", n_entries_o, 2);
    commit_seq(0);

    commit_seq(0);

    for (int i = 0; i < 33; i++) load_one(rnd_ent(), 1'b1);
    chk("n_full", n_entries_o, 31);
    chk("ready_full", ld_ready_o, 0);
    commit_seq(0);

    for (int i = 0; i < 3; i++) load_one(rnd_ent(), 1'b1);
    commit_seq(1);

    for (int i = 0; i < 5; i++) load_one(rnd_ent(), 1'b1);
    for (int i = 0; i < 5; i++) exp_wr.push_back({5'd5, 5'(i), model[i]});
    commit_i = 1'b1;
    @(negedge clk_sys_i);
    commit_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen < 3; c++) begin
      @(posedge clk_sys_i); #2;
      if (r_pll_ctl0_o[5]) seen++;
    end
    chk("reach_strobe3", seen, 3);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_ctl", {r_pll_ctl0_o, r_pll_ctl1_o}, 64'd0);
    chk("midrst_flags", {ld_ready_o, busy_o, done_o, err_o, n_entries_o}, {1'b1, 3'b0, 5'd0});
    exp_wr.delete();
    model.delete();
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;
    repeat (10) @(negedge clk_sys_i);
    chk("midrst_quiet", {err_o, done_o, busy_o, n_entries_o}, 0);

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) load_one(rnd_ent(), 1'b0);
        load_one(rnd_ent(), 1'b1);
      end
      chk("n_rand", n_entries_o, 5'(n));
      commit_seq(int'($urandom_range(0, 1)));
    end

`ifdef PLL_DRP_LOADER_TIMEOUT_EN
    load_one(rnd_ent(), 1'b1);
    load_one(rnd_ent(), 1'b1);
    commit_seq(2);
`endif

    repeat (5) @(negedge clk_sys_i);
    chk("queues_drained", exp_wr.size() + exp_trig.size() + exp_end.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
